dmem_responder: RTL

- Memory-side responder for the pipelined core's data port.
- Accepts one load/store request at a time over a valid/ready handshake and performs the access on an internal word-organised RAM after a configurable latency.
- Returns load data, already lane-selected and sign- or zero-extended, over a valid/ready response channel.
- Replaces the zero-latency data memory when the team models slow memory.

---
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, performed after LATENCY cycles, with lane select and extension.
// Optional misalignment/reserved-size error reporting is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int AW    = IDX_W + 2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [31:0]      rd_word;
    logic             access;
    logic             align_err;
    logic             mem_we;
    logic [3:0]       be;
    logic [31:0]      wr_data;
    logic [31:0]      ld_val;
    logic [7:0]       lane8;
    logic [15:0]      lane16;

    // Address bits above the RAM's byte range are deliberately dropped, so accesses wrap.
    if (ADDR_WIDTH > AW) begin : g_addr_wrap
        logic unused_addr_bits;
        assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:AW];
    end

    assign idx     = addr_q[AW-1:2];
    assign off     = addr_q[1:0];
    assign rd_word = mem[idx];
    assign access  = (state_q == WAIT) && (cnt_q == 4'd0);
    assign mem_we  = access && we_q && !align_err;

    always_comb begin
        align_err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        align_err = (size_q == 2'b11)
                 || (size_q == 2'b01 && off[0])
                 || (size_q == 2'b00 && off != 2'b00);
`endif
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        be      = 4'b1111;
        wr_data = wdata_q;
        ld_val  = rd_word;
        lane8   = rd_word[{off, 3'b000} +: 8];
        lane16  = off[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b10: begin
                be      = 4'b0001 << off;
                wr_data = {4{wdata_q[7:0]}};
                ld_val  = uns_q ? {24'h0, lane8} : {{24{lane8[7]}}, lane8};
            end
            2'b01: begin
                be      = off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
                ld_val  = uns_q ? {16'h0, lane16} : {{16{lane16[15]}}, lane16};
            end
            default: begin
                be      = 4'b1111;
                wr_data = wdata_q;
                ld_val  = rd_word;
            end
        endcase
    end

    // cnt_q counts the wait cycles still to go; the access happens on the edge that leaves WAIT at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[AW-1:0];
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = (we_q || align_err) ? 32'h0 : ld_val;
                    err_d   = align_err;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the RAM array has no reset; a reset port on storage would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
